instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
//   Encodes MIPS-style instruction requests (R, lw, sw, beq, j) into 32-bit
//   words, queues them in a small FIFO and streams them into instruction
//   memory at consecutive word addresses starting at BASE_ADDR. The block
//   halts after IMEM_WORDS completed writes.
//
// Ports
//   clk, reset          single clock, async active-high reset
//   in_valid/in_ready   request handshake
//   in_kind             0=R 1=lw 2=sw 3=beq 4=j, 5-7 illegal
//   in_rs..in_target    instruction fields
//   imem_we/imem_ready  memory write handshake
//   imem_addr           byte address of the current write
//   imem_wdata          encoded word at the FIFO head
//   words_written       completed memory writes
//   mem_full            IMEM_WORDS writes done, block halted
//   err_illegal         sticky flag: an illegal kind was accepted
module instr_encoder #(
  parameter int          DEPTH      = 4,
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        imem_we,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [15:0] words_written,
  output logic        mem_full,
  output logic        err_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // state | meaning
  // IDLE  | FIFO empty, no write pending
  // WRITE | FIFO non-empty, imem_we asserted
  // FULL  | IMEM_WORDS writes completed, halted until reset
  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  state_t        state;
  logic [31:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [31:0]   enc_word;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic          last_write;

  always_comb begin
    enc_word = 32'h0;
    legal    = 1'b1;
    case (in_kind)
      3'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      3'd1:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      3'd2:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      3'd3:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
      3'd4:    enc_word = {6'b000010, in_target};
      default: legal    = 1'b0;
    endcase
  end

  // in_ready looks only at the registered count, so a pop in the same cycle
  // never opens a slot early.
  assign in_ready   = (count < CW'(DEPTH)) && !mem_full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && legal;
  assign pop        = imem_we && imem_ready;
  assign last_write = pop && (({1'b0, words_written} + 17'd1) == 17'(IMEM_WORDS));

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  assign mem_full   = (state == FULL);
  assign imem_we    = (state == WRITE);
  assign imem_wdata = imem_we ? fifo_mem[rd_ptr] : 32'h0;

  // Storage needs no reset: the output is gated to zero unless a valid head exists.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      imem_addr     <= BASE_ADDR;
      words_written <= 16'h0;
      err_illegal   <= 1'b0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        imem_addr     <= imem_addr + 32'd4;
        words_written <= words_written + 16'd1;
      end
      if (accept && !legal) err_illegal <= 1'b1;
      case (state)
        IDLE:    if (count_next != '0) state <= WRITE;
        WRITE: begin
          if (last_write)              state <= FULL;
          else if (count_next == '0)   state <= IDLE;
        end
        FULL:    state <= FULL;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
